alu_chrom_stim_gen: RTL
=======================

ALU_CHROM_STIM_GEN -- requirements
Module: alu_chrom_stim_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: ALU operand width, range 1..32.
REQ-002 SHALL have parameter OP_WIDTH, default 4: ALU opcode width.
REQ-003 SHALL have parameters A_RANGES, B_RANGES and D_RANGES, defaults 8, 8 and 4: range-table depths, each a power of 2 and at least 2.
REQ-004 SHALL have parameter DELAY_WIDTH, default 4: inter-transaction delay width.
REQ-005 SHALL have parameter TRANS_COUNT, default 2: transactions per START, at least 1.
REQ-006 SHALL have parameter SEED, default 0: LFSR seed; a value of 0 SHALL load 32'h1.
REQ-007 SHALL have the following ports; CLK and RST come first.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- CFG_WE  in  1  range-table write strobe.
- CFG_SEL  in  2  table select: 0=A, 1=B, 2=delay, 3=none.
- CFG_IDX  in  clog2(max depth)  entry index.
- CFG_MIN  in  DATA_WIDTH  range minimum.
- CFG_MAX  in  DATA_WIDTH  range maximum.
- START  in  1  begin a batch.
- BUSY  out  1  batch in progress.
- DONE  out  1  one-cycle end-of-batch pulse.
- TX_VALID  out  1  transaction valid.
- TX_READY  in  1  ALU driver accepts.
- TX_A  out  DATA_WIDTH  operand A.
- TX_B  out  DATA_WIDTH  operand B.
- TX_OP  out  OP_WIDTH  opcode.

Function
REQ-008 SHALL use a 32-bit Galois LFSR with taps 32'h80200003; the LFSR SHALL step exactly once in each of the states SEL, GEN_A, GEN_B and GEN_D, and each of those states SHALL use the post-step value rnd.
REQ-009 SHALL implement the FSM IDLE -> SEL -> GEN_A -> GEN_B -> GEN_D -> DRIVE -> (WAIT) -> SEL or IDLE; every state except DRIVE and WAIT SHALL last exactly one cycle.
REQ-010 SHALL, in IDLE, move to SEL and set BUSY=1 on the edge where START=1; START SHALL be ignored in every other state.
REQ-011 SHALL, in SEL, take idxA from the lowest bits of rnd, then idxB, then idxD, then opcode in consecutive higher bit fields, and register opcode into TX_OP.
REQ-012 SHALL, in GEN_A, GEN_B and GEN_D, form the value as clamp(rnd[W-1:0], min[idx], max[idx]), where W is DATA_WIDTH for A and B and DELAY_WIDTH for the delay: below min gives min, above max gives max, otherwise rnd unchanged.
REQ-013 SHALL output min whenever min>max for the selected entry.
REQ-014 SHALL hold TX_VALID=1 in DRIVE with TX_A, TX_B and TX_OP stable until the cycle with TX_READY=1.
REQ-015 SHALL, after a handshake, increment the transaction counter; if the count equals TRANS_COUNT the FSM SHALL go to IDLE with BUSY=0 and DONE=1 for one cycle and no delay; otherwise it SHALL go to WAIT for the drawn delay in cycles, or directly to SEL when the delay is 0.
REQ-016 SHALL ignore CFG_WE while BUSY=1.
REQ-017 SHALL, when CFG_WE=1 and BUSY=0, write {CFG_MIN, CFG_MAX} to the selected entry on that edge; the delay table SHALL store only the low DELAY_WIDTH bits; CFG_SEL=3 SHALL have no effect.
REQ-018 SHALL ignore a write whose CFG_IDX is at or beyond the selected table's depth.
REQ-019 SHALL keep the LFSR value from the end of one batch into the next START, so batches do not repeat.
REQ-020 SHALL assert TX_VALID for the first time exactly 4 cycles after the START edge.

Reset
REQ-021 SHALL, on RST=1 at a rising edge, set FSM=IDLE, BUSY=0, DONE=0, TX_VALID=0, TX_A=0, TX_B=0, TX_OP=0, counter=0 and LFSR=SEED (or 1 when SEED=0), and reset every table entry to min=0 and max=all ones.
REQ-022 SHALL apply RST with priority over every other input, including mid-batch and during a handshake cycle.

Verification
REQ-023 SHALL cover this scenario: all A and B entries set to min=max=8'h5A, START -> every TX_A=TX_B=8'h5A, exactly 2 handshakes, then a DONE pulse.
REQ-024 SHALL cover this scenario: default tables, SEED=0, START at edge k with TX_READY tied to 1 -> TX_VALID at edge k+4, and TX_A equal to the third LFSR value from 1 (low DATA_WIDTH bits).
REQ-025 SHALL cover this scenario: delay entries set to min=max=3, TX_READY=1 -> exactly 3 idle cycles plus 4 generation cycles between the two handshakes.
REQ-026 SHALL cover this scenario: TX_READY held at 0 for 10 cycles in DRIVE -> TX_VALID=1 and TX_A/TX_B/TX_OP unchanged throughout, with a single transfer when TX_READY rises.
REQ-027 SHALL cover this scenario: A entry 0 written with min=8'hF0 and max=8'h10 -> any transaction drawing idxA=0 gives TX_A=8'hF0; a CFG_WE pulse while BUSY=1 leaves the table unchanged.
REQ-028 SHALL cover this scenario: RST asserted for one cycle while in WAIT -> the next cycle shows IDLE with BUSY=0, DONE=0 and TX_VALID=0, and a new START reproduces the scenario REQ-024 sequence.

Source files
------------

// File: rtl/alu_chrom_stim_gen.sv
// Constrained-random ALU stimulus generator. Each START produces TRANS_COUNT
// transactions whose operands are drawn from a Galois LFSR and clamped into
// per-entry [min,max] ranges. A random delay separates the transactions.
//
// Handshake: a transfer happens on a rising CLK edge where TX_VALID and
// TX_READY are both 1. Once TX_VALID is raised, TX_VALID, TX_A, TX_B and TX_OP
// hold their values until that edge. TX_READY may toggle freely.
module alu_chrom_stim_gen #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          OP_WIDTH    = 4,
  parameter int          A_RANGES    = 8,
  parameter int          B_RANGES    = 8,
  parameter int          D_RANGES    = 4,
  parameter int          DELAY_WIDTH = 4,
  parameter int          TRANS_COUNT = 2,
  parameter logic [31:0] SEED        = 32'h0,
  localparam int         MAX_AB      = (A_RANGES > B_RANGES) ? A_RANGES : B_RANGES,
  localparam int         MAX_DEPTH   = (MAX_AB > D_RANGES) ? MAX_AB : D_RANGES,
  localparam int         IDX_W       = $clog2(MAX_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CFG_WE,
  input  logic [1:0]            CFG_SEL,
  input  logic [IDX_W-1:0]      CFG_IDX,
  input  logic [DATA_WIDTH-1:0] CFG_MIN,
  input  logic [DATA_WIDTH-1:0] CFG_MAX,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] TX_A,
  output logic [DATA_WIDTH-1:0] TX_B,
  output logic [OP_WIDTH-1:0]   TX_OP
);

  localparam logic [31:0] TAPS      = 32'h80200003;
  localparam logic [31:0] SEED_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int          AW        = $clog2(A_RANGES);
  localparam int          BW        = $clog2(B_RANGES);
  localparam int          DW        = $clog2(D_RANGES);
  localparam int          OFS_B     = AW;
  localparam int          OFS_D     = AW + BW;
  localparam int          OFS_OP    = AW + BW + DW;
  localparam int          CNT_W     = $clog2(TRANS_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRANS_COUNT - 1);
  localparam logic [31:0] A_DEPTH   = 32'(A_RANGES);
  localparam logic [31:0] B_DEPTH   = 32'(B_RANGES);
  localparam logic [31:0] D_DEPTH   = 32'(D_RANGES);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_GEN_A, S_GEN_B, S_GEN_D, S_DRIVE, S_WAIT
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_a;
  logic [DATA_WIDTH-1:0]  r_b;
  logic [OP_WIDTH-1:0]    r_op;
  logic [CNT_W-1:0]       r_cnt;
  logic [31:0]            r_lfsr;
  logic [AW-1:0]          r_idx_a;
  logic [BW-1:0]          r_idx_b;
  logic [DW-1:0]          r_idx_d;
  logic [DELAY_WIDTH-1:0] r_delay;
  logic [DELAY_WIDTH-1:0] r_wait;

  logic [DATA_WIDTH-1:0]  r_a_min [A_RANGES];
  logic [DATA_WIDTH-1:0]  r_a_max [A_RANGES];
  logic [DATA_WIDTH-1:0]  r_b_min [B_RANGES];
  logic [DATA_WIDTH-1:0]  r_b_max [B_RANGES];
  logic [DELAY_WIDTH-1:0] r_d_min [D_RANGES];
  logic [DELAY_WIDTH-1:0] r_d_max [D_RANGES];

  logic [31:0]            w_rnd;
  logic [31:0]            w_idx32;
  logic [DATA_WIDTH-1:0]  w_val_a;
  logic [DATA_WIDTH-1:0]  w_val_b;
  logic [DELAY_WIDTH-1:0] w_val_d;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Inverted ranges (min > max) resolve to min.
  function automatic logic [31:0] clamp32(input logic [31:0] v,
                                          input logic [31:0] mn,
                                          input logic [31:0] mx);
    logic [31:0] r;
    if (mn > mx)      r = mn;
    else if (v < mn)  r = mn;
    else if (v > mx)  r = mx;
    else              r = v;
    return r;
  endfunction

  assign w_rnd   = lfsr_step(r_lfsr);
  assign w_idx32 = 32'(CFG_IDX);
  assign w_val_a = DATA_WIDTH'(clamp32(32'(w_rnd[DATA_WIDTH-1:0]),
                                       32'(r_a_min[r_idx_a]), 32'(r_a_max[r_idx_a])));
  assign w_val_b = DATA_WIDTH'(clamp32(32'(w_rnd[DATA_WIDTH-1:0]),
                                       32'(r_b_min[r_idx_b]), 32'(r_b_max[r_idx_b])));
  assign w_val_d = DELAY_WIDTH'(clamp32(32'(w_rnd[DELAY_WIDTH-1:0]),
                                        32'(r_d_min[r_idx_d]), 32'(r_d_max[r_idx_d])));

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign TX_VALID = r_valid;
  assign TX_A     = r_a;
  assign TX_B     = r_b;
  assign TX_OP    = r_op;

  // Range tables: writable only between batches, out-of-range indices dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < A_RANGES; i++) begin
        r_a_min[i] <= '0;
        r_a_max[i] <= '1;
      end
      for (int i = 0; i < B_RANGES; i++) begin
        r_b_min[i] <= '0;
        r_b_max[i] <= '1;
      end
      for (int i = 0; i < D_RANGES; i++) begin
        r_d_min[i] <= '0;
        r_d_max[i] <= '1;
      end
    end else if (CFG_WE && !r_busy) begin
      case (CFG_SEL)
        2'd0: if (w_idx32 < A_DEPTH) begin
          r_a_min[CFG_IDX[AW-1:0]] <= CFG_MIN;
          r_a_max[CFG_IDX[AW-1:0]] <= CFG_MAX;
        end
        2'd1: if (w_idx32 < B_DEPTH) begin
          r_b_min[CFG_IDX[BW-1:0]] <= CFG_MIN;
          r_b_max[CFG_IDX[BW-1:0]] <= CFG_MAX;
        end
        2'd2: if (w_idx32 < D_DEPTH) begin
          r_d_min[CFG_IDX[DW-1:0]] <= DELAY_WIDTH'(CFG_MIN);
          r_d_max[CFG_IDX[DW-1:0]] <= DELAY_WIDTH'(CFG_MAX);
        end
        default: ;
      endcase
    end
  end

  // Batch sequencer: draw indices/opcode, draw A, B, delay, drive, wait.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_lfsr  <= SEED_INIT;
      r_idx_a <= '0;
      r_idx_b <= '0;
      r_idx_d <= '0;
      r_delay <= '0;
      r_wait  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_SEL;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_SEL: begin
          r_lfsr  <= w_rnd;
          r_idx_a <= w_rnd[0 +: AW];
          r_idx_b <= w_rnd[OFS_B +: BW];
          r_idx_d <= w_rnd[OFS_D +: DW];
          r_op    <= w_rnd[OFS_OP +: OP_WIDTH];
          r_state <= S_GEN_A;
        end
        S_GEN_A: begin
          r_lfsr  <= w_rnd;
          r_a     <= w_val_a;
          r_state <= S_GEN_B;
        end
        S_GEN_B: begin
          r_lfsr  <= w_rnd;
          r_b     <= w_val_b;
          r_state <= S_GEN_D;
        end
        S_GEN_D: begin
          r_lfsr  <= w_rnd;
          r_delay <= w_val_d;
          r_valid <= 1'b1;
          r_state <= S_DRIVE;
        end
        S_DRIVE: begin
          if (TX_READY) begin
            r_valid <= 1'b0;
            if (r_cnt == CNT_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (r_delay == '0) begin
                r_state <= S_SEL;
              end else begin
                r_wait  <= r_delay;
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (r_wait == DELAY_WIDTH'(1)) r_state <= S_SEL;
          else                           r_wait  <= r_wait - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
